// File: rtl/wishbone_ram_slave_pkg.sv
// Shared constants for the wishbone RAM responder: FSM state encodings,
// the all-zero data word and a byte-lane write-enable helper.
package wishbone_ram_slave_pkg;

    localparam logic [1:0] WB_IDLE = 2'd0;
    localparam logic [1:0] WB_WAIT = 2'd1;
    localparam logic [1:0] WB_RESP = 2'd2;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    // Per-lane write enables: the latched select bits, qualified by the
    // single "commit this write now" condition.
    function automatic logic [3:0] lane_enables(input logic [3:0] sel, input logic commit);
        return sel & {4{commit}};
    endfunction

endpackage

// File: rtl/wishbone_ram_slave_ram_array.sv
// Word-organised RAM, 32-bit words with four byte-lane write enables,
// one write port and a registered read port. The array itself has no reset.
// The read register reloads to zero on every cycle without a read so that
// it can drive the bus data output directly.
module wb_ram_array
    import wishbone_ram_slave_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic [3:0]            wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_idx,
    input  logic [31:0]           wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_idx,
    output logic [31:0]           rd_data
);

    logic [31:0] mem [2**ADDR_WIDTH];

    // Byte-lane write: only lanes with an enable bit set are updated.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_en[b]) begin
                mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    // Registered read; the register holds zero on every cycle without a read.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_idx];
        end else begin
            rd_data <= ZERO_WORD;
        end
    end

endmodule

// File: rtl/wishbone_ram_slave.sv
// Wishbone classic-cycle responder in front of an on-chip RAM.
// The FSM moves IDLE -> WAIT (programmable wait states) -> RESP, and RESP
// lasts exactly one cycle with either ack or err. The RAM access happens on
// the edge that enters RESP. On that edge from IDLE (zero wait states) the
// live bus inputs are used; from WAIT the latched request is used.
module wishbone_ram_slave
    import wishbone_ram_slave_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 12,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wishbone_addr_i,
    input  logic [31:0] wishbone_data_i,
    input  logic        wishbone_we_i,
    input  logic [3:0]  wishbone_sel_i,
    input  logic        wishbone_stb_i,
    input  logic        wishbone_cyc_i,
    output logic [31:0] wishbone_data_o,
    output logic        wishbone_ack_o,
    output logic        wishbone_err_o
);

    localparam logic [3:0] WS_CNT = 4'(WAIT_STATES);

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;
    logic        go_resp;

    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic        we_q;
    logic [3:0]  sel_q;

    logic        req;
    logic        in_idle;
    logic [31:0] cur_addr;
    logic [31:0] cur_data;
    logic        cur_we;
    logic [3:0]  cur_sel;
    logic        hit;
    logic [3:0]  ram_wr_en;
    logic        ram_rd_en;

    assign req     = wishbone_cyc_i & wishbone_stb_i;
    assign in_idle = (state == WB_IDLE);

    // Pick the request being served: live inputs in IDLE, latched copy later.
    always_comb begin
        if (in_idle) begin
            cur_addr = wishbone_addr_i;
            cur_data = wishbone_data_i;
            cur_we   = wishbone_we_i;
            cur_sel  = wishbone_sel_i;
        end else begin
            cur_addr = addr_q;
            cur_data = data_q;
            cur_we   = we_q;
            cur_sel  = sel_q;
        end
    end

    assign hit = (cur_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);

    // Next-state and wait-counter logic; go_resp marks the edge entering RESP.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        go_resp   = 1'b0;
        case (state)
            WB_IDLE: begin
                if (req) begin
                    cnt_nxt = WS_CNT;
                    if (WS_CNT == 4'd0) begin
                        state_nxt = WB_RESP;
                        go_resp   = 1'b1;
                    end else begin
                        state_nxt = WB_WAIT;
                    end
                end else begin
                    state_nxt = WB_IDLE;
                end
            end
            WB_WAIT: begin
                if (!wishbone_cyc_i) begin
                    state_nxt = WB_IDLE;
                    cnt_nxt   = 4'd0;
                end else if (cnt == 4'd1) begin
                    state_nxt = WB_RESP;
                    go_resp   = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            WB_RESP: begin
                state_nxt = WB_IDLE;
            end
            default: begin
                state_nxt = WB_IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // RAM strobes, suppressed while reset is asserted so a reset mid-cycle never writes.
    always_comb begin
        ram_wr_en = lane_enables(cur_sel, go_resp & hit & cur_we & rst);
        ram_rd_en = go_resp & hit & ~cur_we & rst;
    end

    // FSM state, wait counter and the one-cycle ack/err pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= WB_IDLE;
            cnt            <= 4'd0;
            wishbone_ack_o <= 1'b0;
            wishbone_err_o <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            wishbone_ack_o <= go_resp & hit;
            wishbone_err_o <= go_resp & ~hit;
        end
    end

    // Capture the request when it is accepted in IDLE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_q <= ZERO_WORD;
            data_q <= ZERO_WORD;
            we_q   <= 1'b0;
            sel_q  <= 4'h0;
        end else if (in_idle && req) begin
            addr_q <= wishbone_addr_i;
            data_q <= wishbone_data_i;
            we_q   <= wishbone_we_i;
            sel_q  <= wishbone_sel_i;
        end else begin
            addr_q <= addr_q;
            data_q <= data_q;
            we_q   <= we_q;
            sel_q  <= sel_q;
        end
    end

    // The RAM read register is the data_o output register: it is loaded only
    // for a read hit and is zero in every other cycle, including reset.
    wb_ram_array #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_wr_en),
        .wr_idx  (cur_addr[ADDR_WIDTH+1:2]),
        .wr_data (cur_data),
        .rd_en   (ram_rd_en),
        .rd_idx  (cur_addr[ADDR_WIDTH+1:2]),
        .rd_data (wishbone_data_o)
    );

endmodule
